// File: rtl/lsu_mem_stage.sv
// Load/store access unit between the core's EXE state and the data SRAM: byte/half/word access with sign/zero extension.
// Define LSU_ALE_CHECK_EN to compile in address-alignment fault detection (FAULT state, resp_ale/resp_badv).
module lsu_mem_stage #(
    parameter int SRAM_RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_dest,
    output logic        resp_valid,
    output logic        resp_is_load,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_dest,
    output logic        resp_ale,
    output logic [31:0] resp_badv,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCESS = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
`ifdef LSU_ALE_CHECK_EN
    localparam logic [2:0] S_FAULT  = 3'd4;
`endif
    localparam logic [1:0] LAT_INIT = 2'(SRAM_RD_LATENCY - 1);

    logic [2:0]  r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_dest;
    logic [1:0]  r_cnt;
    logic [31:0] r_respData;
    logic [4:0]  r_respDest;
    logic        r_respIsLoad;

    logic        w_accept;
    logic        w_inAccess;
    logic [3:0]  w_storeWe;
    logic [31:0] w_storeData;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadData;

    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign w_inAccess = (r_state == S_ACCESS);

`ifdef LSU_ALE_CHECK_EN
    logic        w_misaligned;
    logic        r_respAle;
    logic [31:0] r_respBadv;

    assign w_misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

    // Response fields are loaded on the way into DONE and held until the next completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_dest       <= 5'd0;
            r_cnt        <= 2'd0;
            r_respData   <= 32'd0;
            r_respDest   <= 5'd0;
            r_respIsLoad <= 1'b0;
`ifdef LSU_ALE_CHECK_EN
            r_respAle    <= 1'b0;
            r_respBadv   <= 32'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_dest     <= req_dest;
`ifdef LSU_ALE_CHECK_EN
                        r_respAle  <= 1'b0;
                        r_state    <= w_misaligned ? S_FAULT : S_ACCESS;
`else
                        r_state    <= S_ACCESS;
`endif
                    end
                end
                S_ACCESS: begin
                    if (r_we) begin
                        r_respData   <= 32'd0;
                        r_respIsLoad <= 1'b0;
                        r_respDest   <= r_dest;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt   <= LAT_INIT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_respData   <= w_loadData;
                        r_respIsLoad <= 1'b1;
                        r_respDest   <= r_dest;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
`ifdef LSU_ALE_CHECK_EN
                S_FAULT: begin
                    r_respData   <= 32'd0;
                    r_respIsLoad <= ~r_we;
                    r_respDest   <= r_dest;
                    r_respAle    <= 1'b1;
                    r_respBadv   <= r_addr;
                    r_state      <= S_DONE;
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Store lane enables and replicated write data, taken from the latched request.
    always_comb begin
        w_storeWe   = 4'b1111;
        w_storeData = r_wdata;
        case (r_size)
            2'd0: begin
                w_storeWe   = 4'b0001 << r_addr[1:0];
                w_storeData = {4{r_wdata[7:0]}};
            end
            2'd1: begin
                w_storeWe   = r_addr[1] ? 4'b1100 : 4'b0011;
                w_storeData = {2{r_wdata[15:0]}};
            end
            default: begin
                w_storeWe   = 4'b1111;
                w_storeData = r_wdata;
            end
        endcase
    end

    assign w_byte = data_sram_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = data_sram_rdata[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_loadData = data_sram_rdata;
        case (r_size)
            2'd0:    w_loadData = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'd1:    w_loadData = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_loadData = data_sram_rdata;
        endcase
    end

    // The strobe and write enables are forced low while reset is held, whatever the state.
    assign req_ready       = (r_state == S_IDLE);
    assign resp_valid      = (r_state == S_DONE) && !reset;
    assign resp_is_load    = r_respIsLoad;
    assign resp_data       = r_respData;
    assign resp_dest       = r_respDest;
    assign data_sram_en    = w_inAccess && !reset;
    assign data_sram_we    = (w_inAccess && !reset && r_we) ? w_storeWe : 4'b0000;
    assign data_sram_addr  = w_inAccess ? {r_addr[31:2], 2'b00} : 32'd0;
    assign data_sram_wdata = (w_inAccess && r_we) ? w_storeData : 32'd0;

`ifdef LSU_ALE_CHECK_EN
    assign resp_ale  = r_respAle;
    assign resp_badv = r_respBadv;
`else
    assign resp_ale  = 1'b0;
    assign resp_badv = 32'd0;
`endif
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: two instances (read latency 1 and 3) on a shared SRAM model,
// directed test-plan cases plus randomized requests checked against a byte-level reference memory.
module tb_lsu_mem_stage;
    localparam int W = 8;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  dest;
    } req_t;

    typedef struct packed {
        logic [7:0] lat;
        logic [7:0] pulses;
        logic [7:0] busy;
        logic [7:0] enCycles;
    } timing_t;

    typedef struct packed {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sramObs_t;

    typedef struct packed {
        logic        isLoad;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        ale;
        logic [31:0] badv;
    } respObs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  validV;
    logic        reqWe;
    logic [1:0]  reqSize;
    logic        reqUns;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [4:0]  reqDest;

    logic [1:0]  ready, respValid, respIsLoad, respAle, sramEn;
    logic [31:0] respData [2];
    logic [31:0] respBadv [2];
    logic [4:0]  respDest [2];
    logic [3:0]  sramWe [2];
    logic [31:0] sramAddr [2];
    logic [31:0] sramWdata [2];
    logic [31:0] sramRdata [2];

    logic [31:0] mem [64];
    logic [31:0] refMem [64];
    logic [31:0] lastBadv;
    logic [31:0] noise;
    logic        preEn;
    logic [5:0]  preIdx;
    logic [31:0] preData;

    int sel;
    int testsRun = 0;
    int failCount = 0;

    lsu_mem_stage #(.SRAM_RD_LATENCY(1)) dutFast (
        .clk(clk), .reset(reset), .req_valid(validV[0]), .req_ready(ready[0]),
        .req_we(reqWe), .req_size(reqSize), .req_unsigned(reqUns), .req_addr(reqAddr),
        .req_wdata(reqWdata), .req_dest(reqDest), .resp_valid(respValid[0]),
        .resp_is_load(respIsLoad[0]), .resp_data(respData[0]), .resp_dest(respDest[0]),
        .resp_ale(respAle[0]), .resp_badv(respBadv[0]), .data_sram_en(sramEn[0]),
        .data_sram_we(sramWe[0]), .data_sram_addr(sramAddr[0]), .data_sram_wdata(sramWdata[0]),
        .data_sram_rdata(sramRdata[0])
    );

    lsu_mem_stage #(.SRAM_RD_LATENCY(3)) dutSlow (
        .clk(clk), .reset(reset), .req_valid(validV[1]), .req_ready(ready[1]),
        .req_we(reqWe), .req_size(reqSize), .req_unsigned(reqUns), .req_addr(reqAddr),
        .req_wdata(reqWdata), .req_dest(reqDest), .resp_valid(respValid[1]),
        .resp_is_load(respIsLoad[1]), .resp_data(respData[1]), .resp_dest(respDest[1]),
        .resp_ale(respAle[1]), .resp_badv(respBadv[1]), .data_sram_en(sramEn[1]),
        .data_sram_we(sramWe[1]), .data_sram_addr(sramAddr[1]), .data_sram_wdata(sramWdata[1]),
        .data_sram_rdata(sramRdata[1])
    );

    // SRAM model: byte-enabled writes, backdoor preload, random data whenever a read is not due.
    always @(posedge clk) begin
        noise <= $urandom;
        if (preEn) mem[preIdx] <= preData;
        for (int g = 0; g < 2; g++) begin
            if (sramEn[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (sramWe[g][b]) mem[sramAddr[g][7:2]][8*b +: 8] <= sramWdata[g][8*b +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : gRead
        localparam int L = (g == 0) ? 1 : 3;
        logic [2:0] pVld = 3'b000;
        logic [5:0] pIdx [3];
        always @(posedge clk) begin
            pVld    <= {pVld[1:0], sramEn[g] && (sramWe[g] == 4'b0000)};
            pIdx[0] <= sramAddr[g][7:2];
            pIdx[1] <= pIdx[0];
            pIdx[2] <= pIdx[1];
        end
        assign sramRdata[g] = pVld[L-1] ? mem[pIdx[L-1]] : noise;
    end

    function automatic int latOf(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    function automatic logic isMis(input req_t r);
        logic m;
        m = 1'b0;
`ifdef LSU_ALE_CHECK_EN
        m = ((r.size == 2'd1) && (r.addr % 2 != 0)) || ((r.size >= 2'd2) && (r.addr % 4 != 0));
`endif
        return m;
    endfunction

    function automatic void laneSpan(input logic [1:0] size, input logic [31:0] addr, output int first, output int n);
        if (size == 2'd0) begin first = int'(addr % 4); n = 1; end
        else if (size == 2'd1) begin first = int'(addr % 4) / 2 * 2; n = 2; end
        else begin first = 0; n = 4; end
    endfunction

    function automatic logic [31:0] expLoad(input logic [31:0] word, input req_t r);
        logic [31:0] v;
        int first, n;
        laneSpan(r.size, r.addr, first, n);
        if (n == 4) return word;
        v = (word >> (8 * first)) % (32'd1 << (8 * n));
        if (!r.uns && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic void predict(input req_t r, input int L, output timing_t t, output sramObs_t s, output respObs_t rs);
        logic m;
        int first, n;
        m = isMis(r);
        t.lat = 8'((m || r.we) ? 2 : 2 + L);
        t.pulses = 8'd1;
        t.busy = t.lat;
        t.enCycles = m ? 8'd0 : 8'd1;
        s = '0;
        if (!m) begin
            s.en = 1'b1;
            s.addr = r.addr - (r.addr % 4);
            if (r.we) begin
                laneSpan(r.size, r.addr, first, n);
                for (int i = 0; i < n; i++) s.we[first + i] = 1'b1;
                s.wdata = (n == 1) ? r.wdata[7:0] * 32'h01010101 :
                          (n == 2) ? r.wdata[15:0] * 32'h00010001 : r.wdata;
            end
        end
        rs.isLoad = !r.we;
        rs.dest = r.dest;
        rs.data = (m || r.we) ? 32'd0 : expLoad(refMem[r.addr[7:2]], r);
        rs.ale = m;
        rs.badv = m ? r.addr : lastBadv;
    endfunction

    task automatic commit(input req_t r);
        int first, n;
        if (isMis(r)) lastBadv = r.addr;
        else if (r.we) begin
            laneSpan(r.size, r.addr, first, n);
            for (int i = 0; i < n; i++) refMem[r.addr[7:2]][8*(first+i) +: 8] = r.wdata[8*i +: 8];
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        preEn = 1'b1;
        preIdx = 6'(idx);
        preData = data;
        refMem[idx] = data;
        @(posedge clk);
        @(negedge clk);
        preEn = 1'b0;
    endtask

    // Drives one request to the selected instance at a negedge and observes W cycles after acceptance.
    task automatic issue(input req_t r, output timing_t t, output sramObs_t s, output respObs_t rs, output respObs_t rsEnd);
        reqWe = r.we; reqSize = r.size; reqUns = r.uns;
        reqAddr = r.addr; reqWdata = r.wdata; reqDest = r.dest;
        validV[sel] = 1'b1;
        t = '0; s = '0; rs = '0; rsEnd = '0;
        @(posedge clk);
        @(negedge clk);
        validV[sel] = 1'b0;
        for (int n = 1; n <= W; n++) begin
            if (n == 1) begin
                s.en = sramEn[sel];
                s.we = sramWe[sel];
                s.addr = sramEn[sel] ? sramAddr[sel] : 32'd0;
                s.wdata = r.we ? sramWdata[sel] : 32'd0;
            end
            if (respValid[sel]) begin
                t.pulses = t.pulses + 8'd1;
                if (t.lat == 8'd0) begin
                    t.lat = 8'(n);
                    rs = {respIsLoad[sel], respDest[sel], respData[sel], respAle[sel], respBadv[sel]};
                end
            end
            if (!ready[sel]) t.busy = t.busy + 8'd1;
            if (sramEn[sel]) t.enCycles = t.enCycles + 8'd1;
            if (n == W) rsEnd = {respIsLoad[sel], respDest[sel], respData[sel], respAle[sel], respBadv[sel]};
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [141:0] got, want;
        reset = 1'b1;
        validV = 2'b00;
        preEn = 1'b0;
        lastBadv = 32'd0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            testsRun++;
            if ({sramEn[g], sramWe[g], respValid[g]} !== 6'd0) begin
                failCount++;
                $display("[TB] FAIL reset_strobe dut%0d: got %h expected 0", g, {sramEn[g], sramWe[g], respValid[g]});
            end
        end
        reset = 1'b0;
        @(negedge clk);
        want = {1'b1, 141'd0};
        for (int g = 0; g < 2; g++) begin
            got = {ready[g], respValid[g], respIsLoad[g], respData[g], respDest[g], respAle[g],
                   respBadv[g], sramEn[g], sramWe[g], sramAddr[g], sramWdata[g]};
            testsRun++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL reset_outputs dut%0d: got %h expected %h", g, got, want);
            end
        end
    endtask

    task automatic test_store_byte();
        req_t r;
        timing_t t, te;
        sramObs_t s, se;
        respObs_t rs, rse, rsEnd;
        sel = 0;
        r = '{we: 1'b1, size: 2'd0, uns: 1'b0, addr: 32'h1C000003, wdata: 32'h000000A5, dest: 5'd3};
        predict(r, latOf(sel), te, se, rse);
        issue(r, t, s, rs, rsEnd);
        commit(r);
        testsRun++;
        if (s !== {1'b1, 4'b1000, 32'h1C000000, 32'hA5A5A5A5}) begin
            failCount++;
            $display("[TB] FAIL store_byte_sram: got %h expected %h", s, {1'b1, 4'b1000, 32'h1C000000, 32'hA5A5A5A5});
        end
        testsRun++;
        if (t.lat !== 8'd2 || t !== te) begin
            failCount++;
            $display("[TB] FAIL store_byte_timing: got %h expected %h", t, te);
        end
        testsRun++;
        if (rs.isLoad !== 1'b0 || rs !== rse) begin
            failCount++;
            $display("[TB] FAIL store_byte_resp: got %h expected %h", rs, rse);
        end
    endtask

    task automatic test_loads();
        req_t r;
        timing_t t, te;
        sramObs_t s, se;
        respObs_t rs, rse, rsEnd;
        logic [1:0]  sizes [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        logic        unsv [6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] addrs [6] = '{32'h102, 32'h103, 32'h101, 32'h102, 32'h100, 32'h100};
        logic [31:0] datas [6] = '{32'hFFFFFFFF, 32'h00000080, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
        sel = 0;
        preload(0, 32'h80FF7F01);
        for (int i = 0; i < 6; i++) begin
            r = '{we: 1'b0, size: sizes[i], uns: unsv[i], addr: addrs[i], wdata: 32'd0, dest: 5'(i + 10)};
            predict(r, latOf(sel), te, se, rse);
            issue(r, t, s, rs, rsEnd);
            testsRun++;
            if (rs.data !== datas[i] || rs.dest !== 5'(i + 10) || rs.isLoad !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL load_%0d_resp: got %h expected data %h dest %0d", i, rs, datas[i], i + 10);
            end
            testsRun++;
            if (t.lat !== 8'd3 || t !== te || s !== se) begin
                failCount++;
                $display("[TB] FAIL load_%0d_timing: got %h/%h expected %h/%h", i, t, s, te, se);
            end
        end
    endtask

    task automatic test_random();
        req_t r;
        timing_t t, te;
        sramObs_t s, se;
        respObs_t rs, rse, rsEnd;
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom_range(1, 0));
            r.we = 1'($urandom_range(1, 0));
            r.size = 2'($urandom_range(3, 0));
            r.uns = 1'($urandom_range(1, 0));
            r.addr = 32'h100 + 32'($urandom_range(255, 0));
            r.wdata = $urandom;
            r.dest = 5'($urandom_range(31, 0));
            predict(r, latOf(sel), te, se, rse);
            issue(r, t, s, rs, rsEnd);
            commit(r);
            testsRun++;
            if (t !== te) begin
                failCount++;
                $display("[TB] FAIL rand_%0d_timing dut%0d: got %h expected %h req %h", i, sel, t, te, r);
            end
            testsRun++;
            if (s !== se) begin
                failCount++;
                $display("[TB] FAIL rand_%0d_sram dut%0d: got %h expected %h req %h", i, sel, s, se, r);
            end
            testsRun++;
            if (rs !== rse) begin
                failCount++;
                $display("[TB] FAIL rand_%0d_resp dut%0d: got %h expected %h req %h", i, sel, rs, rse, r);
            end
            testsRun++;
            if (rsEnd !== rse) begin
                failCount++;
                $display("[TB] FAIL rand_%0d_hold dut%0d: got %h expected %h", i, sel, rsEnd, rse);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] busyM, enM, respM, busyE, enE, respE;
        logic [31:0] d0, d1, dExp;
        int lat, nResp;
        req_t r;
        sel = 1;
        lat = 2 + latOf(sel);
        r = '{we: 1'b0, size: 2'd2, uns: 1'b0, addr: 32'h108, wdata: 32'd0, dest: 5'd7};
        dExp = refMem[r.addr[7:2]];
        busyE = '0; enE = '0; respE = '0;
        for (int k = 0; k < 2; k++) begin
            for (int n = 1; n <= lat; n++) busyE[k * (lat + 1) + n] = 1'b1;
            enE[k * (lat + 1) + 1] = 1'b1;
            respE[k * (lat + 1) + lat] = 1'b1;
        end
        busyM = '0; enM = '0; respM = '0; d0 = '0; d1 = '0; nResp = 0;
        reqWe = r.we; reqSize = r.size; reqUns = r.uns; reqAddr = r.addr; reqWdata = r.wdata; reqDest = r.dest;
        validV[sel] = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == lat + 2) validV[sel] = 1'b0;
            busyM[n] = !ready[sel];
            enM[n] = sramEn[sel];
            respM[n] = respValid[sel];
            if (respValid[sel]) begin
                if (nResp == 0) d0 = respData[sel]; else d1 = respData[sel];
                nResp++;
            end
        end
        validV[sel] = 1'b0;
        testsRun++;
        if (busyM !== busyE) begin
            failCount++;
            $display("[TB] FAIL b2b_ready: got busy mask %h expected %h", busyM, busyE);
        end
        testsRun++;
        if (enM !== enE) begin
            failCount++;
            $display("[TB] FAIL b2b_strobe: got en mask %h expected %h", enM, enE);
        end
        testsRun++;
        if (respM !== respE) begin
            failCount++;
            $display("[TB] FAIL b2b_resp_valid: got mask %h expected %h", respM, respE);
        end
        testsRun++;
        if (d0 !== dExp || d1 !== dExp) begin
            failCount++;
            $display("[TB] FAIL b2b_data: got %h %h expected %h", d0, d1, dExp);
        end
    endtask

    task automatic test_reset_abort();
        int pulses, busy;
        req_t r;
        timing_t t, te;
        sramObs_t s, se;
        respObs_t rs, rse, rsEnd;
        sel = 1;
        reqWe = 1'b0; reqSize = 2'd2; reqUns = 1'b0; reqAddr = 32'h104; reqWdata = 32'd0; reqDest = 5'd9;
        validV[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        validV[sel] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        testsRun++;
        if ({sramEn[sel], sramWe[sel], respValid[sel]} !== 6'd0) begin
            failCount++;
            $display("[TB] FAIL abort_wait_strobe: got %h expected 0", {sramEn[sel], sramWe[sel], respValid[sel]});
        end
        @(negedge clk);
        reset = 1'b0;
        lastBadv = 32'd0;
        #1;
        testsRun++;
        if (ready[sel] !== 1'b1 || respData[sel] !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL abort_wait_idle: got ready %b data %h expected ready 1 data 0", ready[sel], respData[sel]);
        end
        pulses = 0; busy = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (respValid[sel]) pulses++;
            if (!ready[sel]) busy++;
        end
        testsRun++;
        if (pulses !== 0 || busy !== 0) begin
            failCount++;
            $display("[TB] FAIL abort_wait_quiet: got %0d pulses %0d busy cycles expected 0 0", pulses, busy);
        end

        sel = 0;
        reqWe = 1'b1; reqSize = 2'd2; reqAddr = 32'h10C; reqWdata = ~refMem[3]; reqDest = 5'd0;
        validV[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        validV[sel] = 1'b0;
        reset = 1'b1;
        #1;
        testsRun++;
        if ({sramEn[sel], sramWe[sel]} !== 5'd0) begin
            failCount++;
            $display("[TB] FAIL abort_access_strobe: got en %b we %b expected 0 0", sramEn[sel], sramWe[sel]);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        r = '{we: 1'b0, size: 2'd2, uns: 1'b0, addr: 32'h10C, wdata: 32'd0, dest: 5'd4};
        predict(r, latOf(sel), te, se, rse);
        issue(r, t, s, rs, rsEnd);
        testsRun++;
        if (rs !== rse) begin
            failCount++;
            $display("[TB] FAIL abort_access_mem: got %h expected %h", rs, rse);
        end
    endtask

`ifdef LSU_ALE_CHECK_EN
    task automatic test_ale();
        req_t r;
        timing_t t, te;
        sramObs_t s, se;
        respObs_t rs, rse, rsEnd;
        sel = 0;
        r = '{we: 1'b0, size: 2'd2, uns: 1'b0, addr: 32'h1C000002, wdata: 32'd0, dest: 5'd5};
        predict(r, latOf(sel), te, se, rse);
        issue(r, t, s, rs, rsEnd);
        commit(r);
        testsRun++;
        if (t.enCycles !== 8'd0 || t.lat !== 8'd2 || s !== sramObs_t'(0)) begin
            failCount++;
            $display("[TB] FAIL ale_fault_timing: got %h/%h expected no strobe, latency 2", t, s);
        end
        testsRun++;
        if (rs.ale !== 1'b1 || rs.badv !== 32'h1C000002 || rs.data !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL ale_fault_resp: got %h expected ale 1 badv 1c000002 data 0", rs);
        end
        r = '{we: 1'b1, size: 2'd1, uns: 1'b0, addr: 32'h1C000002, wdata: 32'h00001234, dest: 5'd6};
        predict(r, latOf(sel), te, se, rse);
        issue(r, t, s, rs, rsEnd);
        commit(r);
        testsRun++;
        if (s.we !== 4'b1100 || rs.ale !== 1'b0 || rs !== rse) begin
            failCount++;
            $display("[TB] FAIL ale_clear: got we %b resp %h expected we 1100 resp %h", s.we, rs, rse);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        validV = 2'b00;
        preEn = 1'b0;
        reqWe = 1'b0; reqSize = 2'd0; reqUns = 1'b0; reqAddr = '0; reqWdata = '0; reqDest = '0;
        test_reset();
        test_store_byte();
        test_loads();
        test_random();
        test_back_to_back();
        test_reset_abort();
`ifdef LSU_ALE_CHECK_EN
        test_ale();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store access unit sitting directly downstream of the multi-cycle core's EXE state.
- Core hands it one memory request (address, size, store data, destination register); the unit drives the data SRAM port.
- Loads: waits out the SRAM read latency, then extracts the byte, halfword or word and sign/zero-extends it.
- Returns one response pulse that the core consumes in MEM/WB.
- Adds byte and halfword access (ld.b/h/bu/hu, st.b/h) on top of word-only access.

Parameters:
- SRAM_RD_LATENCY, 1, cycles from SRAM read request to valid data_sram_rdata; legal values are 1 to 4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle; request accepted when req_valid and req_ready are both high
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = word (reserved encoding)
- req_unsigned  in  1  load zero-extends when high
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bits significant
- req_dest  in  5  destination GPR for loads
- resp_valid  out  1  single-cycle completion pulse
- resp_is_load  out  1  completed request was a load
- resp_data  out  32  extended load data; 0 for stores
- resp_dest  out  5  req_dest of the completed request
- resp_ale  out  1  address-alignment error (optional feature)
- resp_badv  out  32  faulting address (optional feature)
- data_sram_en  out  1  SRAM access strobe
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  word-aligned address
- data_sram_wdata  out  32  lane-replicated store data
- data_sram_rdata  in  32  SRAM read data

Behaviour:
- State machine: IDLE, ACCESS, WAIT, DONE (plus FAULT when the optional feature is compiled in).
- Reset values: state IDLE. All outputs 0 except req_ready, which is 1.
- req_ready is high only in IDLE. Requests presented in any other state are ignored; the core holds them.
- Accept cycle T: latch we, size, unsigned, addr, wdata and dest into internal registers. Go to ACCESS.
- ACCESS (T+1): data_sram_en is 1 and data_sram_addr = {addr[31:2], 2'b00}. Outputs are driven from the latched request only.
  - Store: data_sram_we per the lane rules below. Go to DONE.
  - Load: data_sram_we = 0. Go to WAIT with counter = SRAM_RD_LATENCY-1.
- WAIT: data_sram_en is 0. The counter decrements each cycle. On the cycle data_sram_rdata is valid (T+1+SRAM_RD_LATENCY), capture it into the extraction register and go to DONE.
- DONE: resp_valid = 1 for exactly one cycle, then IDLE. resp_dest and resp_is_load come from the latched request. Load latency is accept to resp_valid = 2+SRAM_RD_LATENCY cycles; store latency is 2 cycles.
- Store lanes:
  - Byte: we = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: we = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - Word or size 3: we = 4'b1111; wdata passes through unchanged.
- Load extraction:
  - Byte: rdata[8*addr[1:0] +: 8].
  - Half: rdata[16*addr[1] +: 16].
  - Word: all 32 bits.
  - Byte and half are sign-extended unless req_unsigned is set; req_unsigned is ignored for word.
- Misalignment without the optional feature: half ignores addr[0]; word ignores addr[1:0]; the access still happens.
- resp_data, resp_dest and resp_is_load hold their last values after the resp_valid pulse.
- Reset asserted in any state aborts the operation:
  - IDLE is entered next cycle and no resp_valid is issued.
  - data_sram_en and data_sram_we are 0 during every reset cycle.
- Back-to-back: a new request can be accepted in the cycle after DONE (IDLE), never during DONE.

Optional Feature:
- Macro LSU_ALE_CHECK_EN.
- When defined, a request is misaligned if it is a half access with addr[0] = 1, or a word access with addr[1:0] != 0.
- A misaligned request goes from the accept cycle to FAULT. In FAULT: data_sram_en = 0, data_sram_we = 0, and the SRAM is never touched.
- FAULT then goes to DONE, where the response carries resp_ale = 1, resp_badv = addr and resp_data = 0. Fault latency is 2 cycles.
- resp_ale clears to 0 on the next accepted request.
- When the macro is not defined, resp_ale and resp_badv are tied to 0 and no FAULT state exists.

Test Plan:
- Store byte: st.b, addr 0x1C000003, wdata 0x000000A5 -> at T+1 en = 1, addr 0x1C000000, we = 4'b1000, wdata 0xA5A5A5A5; resp_valid at T+2 with resp_is_load = 0.
- Load byte, signed and unsigned: SRAM word 0x80FF7F01 at addr 0x100, SRAM_RD_LATENCY = 1:
  - ld.b at 0x102 -> resp_data 0xFFFFFFFF at T+3.
  - ld.bu at 0x103 -> 0x00000080.
  - ld.b at 0x101 -> 0x0000007F.
- Load half and word: same word, ld.h at 0x102 -> 0xFFFF80FF; ld.hu at 0x100 -> 0x00007F01; ld.w at 0x100 -> 0x80FF7F01 with resp_dest = req_dest.
- Latency sweep: SRAM_RD_LATENCY = 3, ld.w -> resp_valid exactly at T+5; req_ready low from T+1 to T+5; a req_valid held high during that window is accepted at T+6.
- Reset during WAIT: assert reset at T+2 of a load -> no resp_valid; en and we are 0; req_ready = 1 after reset deasserts.
- With LSU_ALE_CHECK_EN: ld.w at 0x1C000002 -> no SRAM strobe; resp_valid at T+2 with resp_ale = 1 and resp_badv = 0x1C000002. Then an aligned st.h at 0x1C000002 -> we = 4'b1100 and resp_ale = 0.
